// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard receiver: synchronizes the keyboard clock/data lines, frames
// 11-bit PS/2 words, and decodes make/break scan codes (set 2) for a small set
// of keys into USB-HID usage codes.
module ps2_keycode_rx #(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode,
  output logic       key_event,
  output logic       frame_err
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_t;
  typedef enum logic [1:0] {BASE, EXT, BREAK} dec_state_t;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   fall;
  logic                   bit_in;

  frame_state_t fstate;
  logic [2:0]   bit_cnt;
  logic [7:0]   shreg;
  logic         par_ok;
  logic [TW-1:0] to_cnt;
  logic         byte_valid;

  dec_state_t   dstate;
  logic         ext_flag;
  logic         brk_flag;
  logic [7:0]   code;

  // Scan-code set 2 to HID usage; extended entries only apply after E0.
  function automatic logic [7:0] translate(input logic [7:0] b, input logic ext);
    logic [7:0] r;
    r = 8'h00;
    if (ext) begin
      case (b)
        8'h75:   r = 8'h52;
        8'h72:   r = 8'h51;
        8'h6B:   r = 8'h50;
        8'h74:   r = 8'h4F;
        default: r = 8'h00;
      endcase
    end
    if (r == 8'h00) begin
      case (b)
        8'h5A:   r = 8'h28;
        8'h1D:   r = 8'h1A;
        8'h1C:   r = 8'h04;
        8'h1B:   r = 8'h16;
        8'h23:   r = 8'h07;
        8'h29:   r = 8'h2C;
        8'h76:   r = 8'h29;
        default: r = 8'h00;
      endcase
    end
    return r;
  endfunction

  // Synchronizer chains; index 0 is the newest sample, idle level is high.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
    end
  end

  // Falling edge: older stage high, newer stage low; data taken from the
  // stage aligned with the newer clock sample.
  always_comb begin
    fall   = clk_sync[SYNC_STAGES-1] & ~clk_sync[SYNC_STAGES-2];
    bit_in = data_sync[SYNC_STAGES-2];
    code   = translate(shreg, ext_flag);
  end

  // Frame FSM with idle timeout; shreg stays stable while the decoder reads it.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      fstate     <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_ok     <= 1'b0;
      to_cnt     <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fall) begin
        to_cnt <= '0;
        case (fstate)
          IDLE: begin
            if (!bit_in) begin
              fstate  <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shreg <= {bit_in, shreg[7:1]};
            if (bit_cnt == 3'd7) fstate <= PARITY;
            else                 bit_cnt <= bit_cnt + 3'd1;
          end
          PARITY: begin
            par_ok <= ^{shreg, bit_in};
            fstate <= STOP;
          end
          STOP: begin
            if (bit_in && par_ok) byte_valid <= 1'b1;
            else                  frame_err  <= 1'b1;
            fstate <= IDLE;
          end
          default: fstate <= IDLE;
        endcase
      end else if (fstate != IDLE) begin
        if (to_cnt == TO_LAST) begin
          fstate    <= IDLE;
          frame_err <= 1'b1;
          to_cnt    <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end else begin
        to_cnt <= '0;
      end
    end
  end

  // Prefix/make/break decoder driving the held-key register.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      dstate    <= BASE;
      ext_flag  <= 1'b0;
      brk_flag  <= 1'b0;
      keycode   <= 8'h00;
      key_event <= 1'b0;
    end else begin
      key_event <= 1'b0;
      if (frame_err) begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
        dstate   <= BASE;
      end else if (byte_valid) begin
        if (shreg == 8'hE0) begin
          ext_flag <= 1'b1;
          dstate   <= (dstate == BREAK) ? BREAK : EXT;
        end else if (shreg == 8'hF0) begin
          brk_flag <= 1'b1;
          dstate   <= BREAK;
        end else begin
          if (!brk_flag) begin
            if (code != 8'h00 && code != keycode) begin
              keycode   <= code;
              key_event <= 1'b1;
            end
          end else if (code != 8'h00 && code == keycode) begin
            keycode   <= 8'h00;
            key_event <= 1'b1;
          end
          ext_flag <= 1'b0;
          brk_flag <= 1'b0;
          dstate   <= BASE;
        end
      end
    end
  end

endmodule

// File: doc/ps2_keycode_rx.md
PS2_KEYCODE_RX -- requirements
Module: ps2_keycode_rx

Interface
REQ-001 SHALL provide parameter TIMEOUT_CYCLES, default 50000, the Clk cycles a partial frame may sit idle before being discarded.
REQ-002 SHALL provide parameter SYNC_STAGES, default 2, the flip-flop depth of the synchronizer on each PS/2 input.
REQ-003 SHALL provide port Clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL provide port Reset_n  input  1  synchronous active-low reset.
REQ-005 SHALL provide port ps2_clk  input  1  keyboard clock, asynchronous to Clk.
REQ-006 SHALL provide port ps2_data  input  1  keyboard data, asynchronous to Clk.
REQ-007 SHALL provide port keycode  output  8  USB-HID code of the key currently held; 8'h00 when none is held.
REQ-008 SHALL provide port key_event  output  1  one-cycle pulse whenever keycode changes value.
REQ-009 SHALL provide port frame_err  output  1  one-cycle pulse on a parity error, a stop-bit error or a timeout.

Function
REQ-010 SHALL pass ps2_clk and ps2_data through SYNC_STAGES flip-flops each, and SHALL detect a falling edge as the last two ps2_clk stages reading 1 then 0.
REQ-011 SHALL implement frame FSM states IDLE, DATA, PARITY and STOP; each transition occurs on a detected falling edge.
REQ-012 In IDLE, a sampled data value of 0 (start bit) SHALL enter DATA with the bit counter at 0; a sampled 1 SHALL stay in IDLE.
REQ-013 In DATA, SHALL shift 8 bits LSB-first, then enter PARITY after the 8th bit (counter 7).
REQ-014 In PARITY, SHALL check odd parity across the 8 data bits plus the parity bit, then enter STOP.
REQ-015 In STOP, a sampled 1 with good parity SHALL deliver the byte to the decoder the following cycle; otherwise SHALL pulse frame_err and discard the byte; both paths return to IDLE.
REQ-016 SHALL keep a timeout counter that clears on every falling edge; if it reaches TIMEOUT_CYCLES-1 while not in IDLE, SHALL return to IDLE and pulse frame_err.
REQ-017 SHALL implement decoder states BASE, EXT (after E0) and BREAK (after F0, or E0 F0); the break flag and the extended flag are held independently.
REQ-018 Byte E0 SHALL set the extended flag; byte F0 SHALL set the break flag; neither byte changes keycode.
REQ-019 SHALL translate any other byte through a fixed table; entries outside the table map to 8'h00.
REQ-020 The translation table SHALL be: 5A->28 (Enter), 1D->1A (W), 1C->04 (A), 1B->16 (S), 23->07 (D), 29->2C (Space), 76->29 (Esc); with the extended flag set: E0 75->52, E0 72->51, E0 6B->50, E0 74->4F (arrows).
REQ-021 A make code with a nonzero translation SHALL load keycode and pulse key_event, unless keycode already holds that value (typematic repeat: no pulse).
REQ-022 A break code whose translation equals keycode SHALL clear keycode to 8'h00 and pulse key_event; a break of any other key SHALL be ignored.
REQ-023 After any non-prefix byte, SHALL clear the extended and break flags and return the decoder to BASE.
REQ-024 A frame error SHALL also clear the extended and break flags; keycode SHALL be unchanged.
REQ-025 Latency SHALL be at most 3 Clk cycles from the falling edge that samples the stop bit to the keycode update.

Reset
REQ-026 While Reset_n is 0 at a rising Clk edge, SHALL force: frame FSM to IDLE; decoder to BASE; flags, counters and shift register to 0; keycode to 8'h00; key_event and frame_err to 0; synchronizer stages to 1.
REQ-027 A reset asserted mid-frame SHALL abandon the frame with no frame_err pulse; the next start bit after release SHALL be received normally.

Verification
REQ-028 Frame 5A (parity 1, stop 1) -> keycode 8'h28 and one key_event pulse within 3 cycles of the stop edge; then F0 5A -> keycode 8'h00 and one key_event pulse.
REQ-029 E0 75 -> keycode 8'h52; E0 F0 75 -> 8'h00; E0 alone followed by 1D -> 8'h1A (the extended flag was consumed correctly).
REQ-030 5A with wrong parity -> one frame_err pulse, keycode stays 8'h00, no key_event; the next valid 1C -> 8'h04.
REQ-031 Start bit plus 4 data bits, then idle TIMEOUT_CYCLES -> one frame_err pulse, FSM back in IDLE; a following frame 29 -> keycode 8'h2C.
REQ-032 Held 5A repeated three times -> keycode 8'h28 with exactly one key_event; F0 1C while 5A is held -> keycode still 8'h28.
REQ-033 Reset_n low during bit 5 of a frame, released, then frame 76 -> keycode 8'h29, and no frame_err at any point.
